// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the PC generation stage.
// Contents: opcode[6:2] constants for control-transfer instructions, the
// default boot address, the FSM state encoding and the redirect priority
// levels used by the pending-redirect buffer.
package pc_gen_unit_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_BOOT,
    S_RUN
  } state_e;

  // Ordered so that a numerically larger value is a higher-priority redirect.
  typedef enum logic [2:0] {
    PRIO_NONE,
    PRIO_BRANCH,
    PRIO_JUMP,
    PRIO_MRET,
    PRIO_TRAP
  } prio_e;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational redirect priority mux and target alignment.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned jump/branch targets
// are flagged and suppressed instead of being forced to word alignment).
// Ports:
//   run            - FSM is in S_RUN (redirects are ignored otherwise)
//   pc_plus_4      - sequential fetch address
//   opcode_6_to_2, branch_taken, iadder - execute-stage control transfer
//   trap_taken, trap_address, mret, epc  - trap entry / return
//   pend_valid, pend_target              - buffered redirect from a stall
//   next_pc        - selected fetch address
//   new_redirect   - a redirect is requested by this cycle's inputs
//   new_prio       - priority of that redirect
//   new_target     - its (aligned) target
//   redirect       - next_pc is a redirect target (new or pending)
//   misaligned     - selected jump/branch target has bit 1 set
module pc_target_sel
  import pc_gen_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic        run,
  input  logic [31:0] pc_plus_4,
  input  logic [4:0]  opcode_6_to_2,
  input  logic        branch_taken,
  input  logic [31:0] iadder,
  input  logic        trap_taken,
  input  logic [31:0] trap_address,
  input  logic        mret,
  input  logic [31:0] epc,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  output logic [31:0] next_pc,
  output logic        new_redirect,
  output prio_e       new_prio,
  output logic [31:0] new_target,
  output logic        redirect,
  output logic        misaligned
);

  logic [31:0] cand;
  prio_e       cand_prio;

  always_comb begin
    cand      = pc_plus_4;
    cand_prio = PRIO_NONE;
    if (trap_taken) begin
      cand      = trap_address;
      cand_prio = PRIO_TRAP;
    end else if (mret) begin
      cand      = epc;
      cand_prio = PRIO_MRET;
    end else begin
      case (opcode_6_to_2)
        OP_JAL: begin
          cand      = iadder;
          cand_prio = PRIO_JUMP;
        end
        OP_JALR: begin
          cand      = iadder & ~32'h1;
          cand_prio = PRIO_JUMP;
        end
        OP_BRANCH: begin
          if (branch_taken) begin
            cand      = iadder;
            cand_prio = PRIO_BRANCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
`ifdef MISALIGN_TRAP_EN
    // Only execute-stage targets are checked; trap/mret targets pass as-is.
    misaligned   = run && cand[1] &&
                   ((cand_prio == PRIO_JUMP) || (cand_prio == PRIO_BRANCH));
    new_redirect = run && (cand_prio != PRIO_NONE) && !misaligned;
    new_target   = cand;
`else
    misaligned   = 1'b0;
    new_redirect = run && (cand_prio != PRIO_NONE);
    new_target   = cand & ~32'h3;
`endif
    new_prio = new_redirect ? cand_prio : PRIO_NONE;
    redirect = new_redirect || (run && pend_valid);

    if (!run) begin
      next_pc = BOOT_ADDR;
    end else if (new_redirect) begin
      next_pc = new_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else begin
      next_pc = pc_plus_4;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generation stage: holds the architectural PC, selects the
// next fetch address, buffers one redirect across fetch stalls and pulses a
// pipeline flush after every redirect.
// Optional feature macro: MISALIGN_TRAP_EN (see pc_target_sel).
// Ports:
//   clk_in, rst_in        - clock, async active-low reset
//   ahb_ready_in          - fetch bus ready; low stalls the PC
//   branch_taken_in, opcode_6_to_2_in, iadder_in - execute-stage redirect
//   trap_taken_in, trap_address_in, mret_in, epc_in - trap entry / return
//   pc_out                - registered current PC
//   pc_plus_4_out         - pc_out + 4 (link value)
//   next_pc_out           - combinational fetch address
//   flush_out             - one-cycle pulse after a redirect is loaded
//   misaligned_instr_out  - selected jump/branch target is misaligned
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            ahb_ready_in,
  input  logic            branch_taken_in,
  input  logic [4:0]      opcode_6_to_2_in,
  input  logic [XLEN-1:0] iadder_in,
  input  logic            trap_taken_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            mret_in,
  input  logic [XLEN-1:0] epc_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic [XLEN-1:0] next_pc_out,
  output logic            flush_out,
  output logic            misaligned_instr_out
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        flush_q;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;
  prio_e       pend_prio_q;

  logic        new_redirect;
  prio_e       new_prio;
  logic [31:0] new_target;
  logic        redirect;

  assign pc_out        = pc_q;
  assign pc_plus_4_out = pc_q + 32'd4;
  assign flush_out     = flush_q;

  pc_target_sel #(
    .BOOT_ADDR (BOOT_ADDR)
  ) u_pc_target_sel (
    .run           (state_q == S_RUN),
    .pc_plus_4     (pc_plus_4_out),
    .opcode_6_to_2 (opcode_6_to_2_in),
    .branch_taken  (branch_taken_in),
    .iadder        (iadder_in),
    .trap_taken    (trap_taken_in),
    .trap_address  (trap_address_in),
    .mret          (mret_in),
    .epc           (epc_in),
    .pend_valid    (pend_valid_q),
    .pend_target   (pend_target_q),
    .next_pc       (next_pc_out),
    .new_redirect  (new_redirect),
    .new_prio      (new_prio),
    .new_target    (new_target),
    .redirect      (redirect),
    .misaligned    (misaligned_instr_out)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= S_BOOT;
      pc_q          <= BOOT_ADDR;
      flush_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_prio_q   <= PRIO_NONE;
    end else begin
      case (state_q)
        S_BOOT: begin
          flush_q <= 1'b0;
          if (ahb_ready_in) begin
            state_q <= S_RUN;
            pc_q    <= next_pc_out;
          end
        end
        S_RUN: begin
          if (ahb_ready_in) begin
            pc_q         <= next_pc_out;
            flush_q      <= redirect;
            pend_valid_q <= 1'b0;
            pend_prio_q  <= PRIO_NONE;
          end else begin
            flush_q <= 1'b0;
            // Keep the most important redirect seen during the stall; a trap
            // always replaces whatever is buffered.
            if (new_redirect && (!pend_valid_q || (new_prio > pend_prio_q) ||
                                 (new_prio == PRIO_TRAP))) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= new_target;
              pend_prio_q   <= new_prio;
            end
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;
  localparam logic [31:0] BOOT = 32'h0000_0100;
  localparam logic [4:0] BR = 5'b11000, JAL = 5'b11011, JALR = 5'b11001, NOP = 5'b00100;

  logic        clk_in, rst_in, ahb_ready_in, branch_taken_in, trap_taken_in, mret_in;
  logic [4:0]  opcode_6_to_2_in;
  logic [31:0] iadder_in, trap_address_in, epc_in;
  logic [31:0] pc_out, pc_plus_4_out, next_pc_out;
  logic        flush_out, misaligned_instr_out;

  pc_gen_unit #(.BOOT_ADDR(BOOT), .XLEN(32)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .ahb_ready_in         (ahb_ready_in),
    .branch_taken_in      (branch_taken_in),
    .opcode_6_to_2_in     (opcode_6_to_2_in),
    .iadder_in            (iadder_in),
    .trap_taken_in        (trap_taken_in),
    .trap_address_in      (trap_address_in),
    .mret_in              (mret_in),
    .epc_in               (epc_in),
    .pc_out               (pc_out),
    .pc_plus_4_out        (pc_plus_4_out),
    .next_pc_out          (next_pc_out),
    .flush_out            (flush_out),
    .misaligned_instr_out (misaligned_instr_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic tk, input logic [4:0] op,
                       input logic [31:0] ia, input logic tr, input logic [31:0] ta,
                       input logic mr, input logic [31:0] ep);
    ahb_ready_in     = rdy;
    branch_taken_in  = tk;
    opcode_6_to_2_in = op;
    iadder_in        = ia;
    trap_taken_in    = tr;
    trap_address_in  = ta;
    mret_in          = mr;
    epc_in           = ep;
  endtask

  typedef struct {
    logic        rdy;
    logic        tk;
    logic [4:0]  op;
    logic [31:0] ia;
    logic        tr;
    logic [31:0] ta;
    logic        mr;
    logic [31:0] ep;
    logic [31:0] exp_next;
    logic [31:0] exp_pc;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[11];

  // Reference model state.
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_pv;
  logic [31:0] m_pt;
  int          m_pp;
  bit          m_flush;

  task automatic model_reset();
    m_boot = 1; m_pc = BOOT; m_pv = 0; m_pt = '0; m_pp = 0; m_flush = 0;
  endtask

  // Priority of this cycle's redirect (0 = none), its target, and the fetch address.
  task automatic model_sel(output int prio, output logic [31:0] tgt,
                           output logic [31:0] nxt, output bit mis);
    prio = 0; tgt = '0; mis = 0;
    if (!m_boot) begin
      if (trap_taken_in) begin prio = 4; tgt = trap_address_in; end
      else if (mret_in) begin prio = 3; tgt = epc_in; end
      else if (opcode_6_to_2_in == JAL) begin prio = 2; tgt = iadder_in; end
      else if (opcode_6_to_2_in == JALR) begin prio = 2; tgt = iadder_in - (iadder_in % 2); end
      else if (opcode_6_to_2_in == BR && branch_taken_in) begin prio = 1; tgt = iadder_in; end
`ifdef MISALIGN_TRAP_EN
      if ((prio == 1 || prio == 2) && ((tgt / 2) % 2 == 1)) begin mis = 1; prio = 0; end
`else
      tgt = tgt - (tgt % 4);
`endif
    end
    if (m_boot) nxt = BOOT;
    else if (prio > 0) nxt = tgt;
    else if (m_pv) nxt = m_pt;
    else nxt = m_pc + 4;
  endtask

  task automatic model_edge(input int prio, input logic [31:0] tgt, input logic [31:0] nxt);
    if (m_boot) begin
      m_flush = 0;
      if (ahb_ready_in) begin m_boot = 0; m_pc = BOOT; end
    end else if (ahb_ready_in) begin
      m_flush = (prio > 0) || m_pv;
      m_pc = nxt;
      m_pv = 0; m_pp = 0;
    end else begin
      m_flush = 0;
      if (prio > 0 && (!m_pv || prio > m_pp || prio == 4)) begin
        m_pv = 1; m_pt = tgt; m_pp = prio;
      end
    end
  endtask

  initial begin
    logic [31:0] prev_pc;
    int          prio;
    logic [31:0] tgt, nxt;
    bit          mis;

    vecs[0]  = '{1, 0, NOP,  32'h0,      0, 32'h0,         0, 32'h0,  32'h100,       32'h100,       0};
    vecs[1]  = '{1, 0, NOP,  32'h0,      0, 32'h0,         0, 32'h0,  32'h104,       32'h104,       0};
    vecs[2]  = '{1, 0, NOP,  32'h0,      0, 32'h0,         0, 32'h0,  32'h108,       32'h108,       0};
    vecs[3]  = '{1, 0, JAL,  32'h200,    0, 32'h0,         0, 32'h0,  32'h200,       32'h200,       1};
    vecs[4]  = '{1, 1, BR,   32'h180,    0, 32'h0,         0, 32'h0,  32'h180,       32'h180,       1};
    vecs[5]  = '{1, 0, JAL,  32'h200,    0, 32'h0,         0, 32'h0,  32'h200,       32'h200,       1};
    vecs[6]  = '{1, 0, BR,   32'h180,    0, 32'h0,         0, 32'h0,  32'h204,       32'h204,       0};
    vecs[7]  = '{1, 0, JALR, 32'h305,    0, 32'h0,         0, 32'h0,  32'h304,       32'h304,       1};
    vecs[8]  = '{1, 1, BR,   32'h180,    1, 32'h8000_0000, 1, 32'h40, 32'h8000_0000, 32'h8000_0000, 1};
    vecs[9]  = '{1, 1, BR,   32'h180,    0, 32'h0,         1, 32'h40, 32'h40,        32'h40,        1};
    vecs[10] = '{1, 1, NOP,  32'h180,    0, 32'h0,         0, 32'h0,  32'h44,        32'h44,        0};

    // Reset state.
    rst_in = 1'b0;
    drive(1, 0, NOP, 0, 0, 0, 0, 0);
    #12;
    chk("reset_pc", pc_out, BOOT);
    chk("reset_flush", {31'b0, flush_out}, 0);
    chk("reset_misaligned", {31'b0, misaligned_instr_out}, 0);
    chk("reset_next_pc", next_pc_out, BOOT);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Directed table, starting in S_BOOT.
    prev_pc = BOOT;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rdy, vecs[i].tk, vecs[i].op, vecs[i].ia, vecs[i].tr, vecs[i].ta,
            vecs[i].mr, vecs[i].ep);
      #1;
      chk($sformatf("vec%0d_next_pc", i), next_pc_out, vecs[i].exp_next);
      chk($sformatf("vec%0d_pc_plus_4", i), pc_plus_4_out, prev_pc + 32'd4);
      @(posedge clk_in); #1;
      chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
      chk($sformatf("vec%0d_flush", i), {31'b0, flush_out}, {31'b0, vecs[i].exp_flush});
      prev_pc = vecs[i].exp_pc;
      @(negedge clk_in);
    end

    // Stall buffering: branch during a stall, two more stall cycles, then ready.
    drive(0, 1, BR, 32'h400, 0, 0, 0, 0);
    @(posedge clk_in); #1;
    chk("stall0_pc", pc_out, 32'h44);
    chk("stall0_flush", {31'b0, flush_out}, 0);
    @(negedge clk_in);
    drive(0, 0, NOP, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_next_pc_pending", next_pc_out, 32'h400);
      @(posedge clk_in); #1;
      chk("stall_pc_hold", pc_out, 32'h44);
      chk("stall_flush", {31'b0, flush_out}, 0);
      @(negedge clk_in);
    end
    ahb_ready_in = 1'b1;
    @(posedge clk_in); #1;
    chk("stall_release_pc", pc_out, 32'h400);
    chk("stall_release_flush", {31'b0, flush_out}, 1);
    @(posedge clk_in); #1;
    chk("stall_after_pc", pc_out, 32'h404);
    chk("stall_after_flush", {31'b0, flush_out}, 0);
    @(negedge clk_in);

    // Misaligned JAL target.
    drive(1, 0, JAL, 32'h202, 0, 0, 0, 0);
    #1;
`ifdef MISALIGN_TRAP_EN
    chk("misalign_flag", {31'b0, misaligned_instr_out}, 1);
    chk("misalign_next_pc", next_pc_out, 32'h408);
    @(posedge clk_in); #1;
    chk("misalign_pc", pc_out, 32'h408);
    chk("misalign_flush", {31'b0, flush_out}, 0);
`else
    chk("misalign_flag", {31'b0, misaligned_instr_out}, 0);
    chk("misalign_next_pc", next_pc_out, 32'h200);
    @(posedge clk_in); #1;
    chk("misalign_pc", pc_out, 32'h200);
    chk("misalign_flush", {31'b0, flush_out}, 1);
`endif
    @(negedge clk_in);

    // Reset in the middle of a stall with a pending redirect.
    drive(0, 1, BR, 32'h700, 0, 0, 0, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    chk("midreset_pc", pc_out, BOOT);
    chk("midreset_flush", {31'b0, flush_out}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    drive(1, 0, NOP, 0, 0, 0, 0, 0);
    #1;
    chk("midreset_boot_next", next_pc_out, BOOT);
    @(posedge clk_in); #1;
    chk("midreset_boot_pc", pc_out, BOOT);
    @(posedge clk_in); #1;
    chk("midreset_no_pending_pc", pc_out, BOOT + 32'd4);
    chk("midreset_no_pending_flush", {31'b0, flush_out}, 0);
    @(negedge clk_in);

    // Randomized run against the reference model, from a fresh reset.
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic [4:0]  op;
      logic [31:0] ia;
      case ($urandom_range(0, 5))
        0: op = BR;
        1: op = JAL;
        2: op = JALR;
        default: op = 5'($urandom);
      endcase
      ia = $urandom;
      if ($urandom_range(0, 2) != 0) ia = ia & ~32'h3;
      drive($urandom_range(0, 2) != 0, 1'($urandom), op, ia,
            $urandom_range(0, 9) == 0, $urandom & ~32'h3,
            $urandom_range(0, 7) == 0, $urandom & ~32'h3);
      #1;
      model_sel(prio, tgt, nxt, mis);
      chk("rand_next_pc", next_pc_out, nxt);
      chk("rand_misaligned", {31'b0, misaligned_instr_out}, {31'b0, mis});
      chk("rand_pc_plus_4", pc_plus_4_out, m_pc + 32'd4);
      @(posedge clk_in);
      model_edge(prio, tgt, nxt);
      #1;
      chk("rand_pc", pc_out, m_pc);
      chk("rand_flush", {31'b0, flush_out}, {31'b0, m_flush});
      @(negedge clk_in);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
